// File: rtl/fifo_sync_flex_if.sv
// Valid/ready word handshake shared by both sides of fifo_sync_flex.
// master drives data/valid, slave drives ready.
interface fifo_sync_flex_if #(
   parameter int Nb = 8
);
   logic [Nb-1:0] data;
   logic          valid;
   logic          ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/fifo_sync_flex.sv
// Synchronous FIFO with prefetched output register, optional bypass, thresholds and flush.
// Occupancy statistics (max_count, overflow) are built only when FIFO_SYNC_FLEX_STATS_EN is defined.
module fifo_sync_flex #(
   parameter int Nb     = 8,
   parameter int M      = 2,
   parameter int BYPASS = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   fifo_sync_flex_if.slave         in,
   fifo_sync_flex_if.master        out,
   input  logic                    flush,
   input  logic [M:0]              af_level,
   input  logic [M:0]              ae_level,
   output logic [M:0]              count,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [M:0]              max_count,
   output logic                    overflow
);
   localparam int N = 1 << M;

   logic [Nb-1:0] r_mem [N];
   logic [M:0]    r_wr_ptr;
   logic [M:0]    r_rd_ptr;
   logic [Nb-1:0] r_out_data;
   logic          r_out_valid;

   logic [M:0]    w_mem_cnt;
   logic [M:0]    w_count;
   logic          w_in_ready;
   logic          w_wr_acc;
   logic          w_slot_open;
   logic          w_mem_empty;
   logic          w_bypass;
   logic          w_mem_wr;

   // The output register counts as one stored word.
   assign w_mem_cnt   = r_wr_ptr - r_rd_ptr;
   assign w_count     = w_mem_cnt + (M+1)'(r_out_valid);
   assign w_in_ready  = (w_count != (M+1)'(N));
   assign w_wr_acc    = in.valid && w_in_ready;
   assign w_slot_open = !r_out_valid || out.ready;
   assign w_mem_empty = (r_wr_ptr == r_rd_ptr);
   assign w_bypass    = (BYPASS != 0) && w_mem_empty && w_slot_open && w_wr_acc;
   assign w_mem_wr    = reset && !flush && w_wr_acc && !w_bypass;

   assign in.ready     = w_in_ready;
   assign out.data     = r_out_data;
   assign out.valid    = r_out_valid;
   assign count        = w_count;
   assign almost_full  = (w_count >= af_level);
   assign almost_empty = (w_count <= ae_level);

   always_ff @(posedge clk) begin
      if (w_mem_wr) begin
         r_mem[r_wr_ptr[M-1:0]] <= in.data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (flush) begin
         // Memory and out.data keep stale contents; only the pointers matter.
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_mem_wr) begin
            r_wr_ptr <= r_wr_ptr + (M+1)'(1);
         end
         if (w_slot_open) begin
            if (!w_mem_empty) begin
               r_out_data  <= r_mem[r_rd_ptr[M-1:0]];
               r_out_valid <= 1'b1;
               r_rd_ptr    <= r_rd_ptr + (M+1)'(1);
            end else if (w_bypass) begin
               r_out_data  <= in.data;
               r_out_valid <= 1'b1;
            end else begin
               r_out_valid <= 1'b0;
            end
         end
      end
   end

`ifdef FIFO_SYNC_FLEX_STATS_EN
   logic [M:0] r_max_count;
   logic       r_overflow;

   // Statistics survive flush; only reset clears them.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_max_count <= '0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_count > r_max_count) begin
            r_max_count <= w_count;
         end
         if (in.valid && !w_in_ready) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign max_count = r_max_count;
   assign overflow  = r_overflow;
`else
   assign max_count = '0;
   assign overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Bench for fifo_sync_flex: BYPASS=0 and BYPASS=1 instances share one directed stimulus,
// each checked every cycle against a queue-based model plus literal expectations.
module tb_fifo_sync_flex;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       s_rst_n, s_wvalid, s_oready, s_flush;
   logic [7:0] s_wdata;
   logic [2:0] s_af, s_ae;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

`ifdef FIFO_SYNC_FLEX_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   fifo_sync_flex_if #(.Nb(8)) wif0 ();
   fifo_sync_flex_if #(.Nb(8)) rif0 ();
   fifo_sync_flex_if #(.Nb(8)) wif1 ();
   fifo_sync_flex_if #(.Nb(8)) rif1 ();

   assign wif0.valid = s_wvalid;
   assign wif0.data  = s_wdata;
   assign rif0.ready = s_oready;
   assign wif1.valid = s_wvalid;
   assign wif1.data  = s_wdata;
   assign rif1.ready = s_oready;

   logic [7:0] w_od  [2];
   logic       w_ov  [2];
   logic       w_rdy [2];
   logic       w_afl [2];
   logic       w_ael [2];
   logic       w_ovf [2];
   logic [2:0] w_cnt [2];
   logic [2:0] w_mx  [2];

   assign w_od[0]  = rif0.data;
   assign w_ov[0]  = rif0.valid;
   assign w_rdy[0] = wif0.ready;
   assign w_od[1]  = rif1.data;
   assign w_ov[1]  = rif1.valid;
   assign w_rdy[1] = wif1.ready;

   fifo_sync_flex #(.Nb(8), .M(2), .BYPASS(0)) dut0 (
      .clk(clk), .reset(s_rst_n), .in(wif0.slave), .out(rif0.master), .flush(s_flush),
      .af_level(s_af), .ae_level(s_ae), .count(w_cnt[0]), .almost_full(w_afl[0]),
      .almost_empty(w_ael[0]), .max_count(w_mx[0]), .overflow(w_ovf[0]));

   fifo_sync_flex #(.Nb(8), .M(2), .BYPASS(1)) dut1 (
      .clk(clk), .reset(s_rst_n), .in(wif1.slave), .out(rif1.master), .flush(s_flush),
      .af_level(s_af), .ae_level(s_ae), .count(w_cnt[1]), .almost_full(w_afl[1]),
      .almost_empty(w_ael[1]), .max_count(w_mx[1]), .overflow(w_ovf[1]));

   function automatic void chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endfunction

   for (genvar g = 0; g < 2; g++) begin : mdl
      logic [7:0] q[$];
      bit         ov  = 1'b0;
      logic [7:0] od  = 8'h00;
      int         mx  = 0;
      bit         ovf = 1'b0;

      always @(posedge clk) begin
         int cnt;
         bit acc, open, byp_done;
         cnt  = q.size() + int'(ov);
         acc  = s_wvalid && (cnt != 4);
         open = !ov || s_oready;
         byp_done = 1'b0;
         if (!s_rst_n) begin
            q.delete();
            ov = 1'b0; od = 8'h00; mx = 0; ovf = 1'b0;
         end else begin
            if (cnt > mx) mx = cnt;
            if (s_wvalid && cnt == 4) ovf = 1'b1;
            if (s_flush) begin
               q.delete();
               ov = 1'b0;
            end else begin
               if (open) begin
                  if (q.size() != 0) begin
                     od = q.pop_front();
                     ov = 1'b1;
                  end else if (g == 1 && acc) begin
                     od = s_wdata;
                     ov = 1'b1;
                     byp_done = 1'b1;
                  end else begin
                     ov = 1'b0;
                  end
               end
               if (acc && !byp_done) q.push_back(s_wdata);
            end
         end
      end

      always @(negedge clk) begin
         if (chk_en) begin
            int c;
            c = q.size() + int'(ov);
            chk($sformatf("count%0d", g), int'(w_cnt[g]), c);
            chk($sformatf("in_ready%0d", g), int'(w_rdy[g]), int'(c != 4));
            chk($sformatf("out_valid%0d", g), int'(w_ov[g]), int'(ov));
            chk($sformatf("out_data%0d", g), int'(w_od[g]), int'(od));
            chk($sformatf("almost_full%0d", g), int'(w_afl[g]), int'(c >= int'(s_af)));
            chk($sformatf("almost_empty%0d", g), int'(w_ael[g]), int'(c <= int'(s_ae)));
            chk($sformatf("max_count%0d", g), int'(w_mx[g]), STATS ? mx : 0);
            chk($sformatf("overflow%0d", g), int'(w_ovf[g]), STATS ? int'(ovf) : 0);
         end
      end
   end

   logic [7:0] got0[$];
   logic [7:0] got1[$];
   always @(negedge clk) begin
      if (chk_en && s_rst_n && !s_flush) begin
         if (w_ov[0] && s_oready) got0.push_back(w_od[0]);
         if (w_ov[1] && s_oready) got1.push_back(w_od[1]);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_seq(input string nm, input int base, input int n);
      chk({nm, "_len0"}, got0.size(), n);
      chk({nm, "_len1"}, got1.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < got0.size()) chk($sformatf("%s0_w%0d", nm, i), int'(got0[i]), base + i);
         if (i < got1.size()) chk($sformatf("%s1_w%0d", nm, i), int'(got1[i]), base + i);
      end
      got0.delete();
      got1.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got still running expected finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      s_rst_n = 1'b0; s_wvalid = 1'b0; s_wdata = 8'h00; s_oready = 1'b0;
      s_flush = 1'b0; s_af = 3'd3; s_ae = 3'd1;
      cyc();
      chk_en = 1'b1;
      cyc();
      chk("rst_count", int'(w_cnt[0]), 0);
      chk("rst_in_ready", int'(w_rdy[0]), 1);
      chk("rst_out_valid", int'(w_ov[1]), 0);
      chk("rst_out_data", int'(w_od[0]), 0);
      chk("rst_almost_empty", int'(w_ael[0]), 1);
      chk("rst_almost_full", int'(w_afl[0]), 0);
      s_rst_n = 1'b1;

      // Fill with A..D while stalled, then E is held off.
      for (int i = 0; i < 4; i++) begin
         s_wvalid = 1'b1;
         s_wdata  = 8'h41 + 8'(i);
         cyc();
         chk($sformatf("fill_count%0d", i), int'(w_cnt[0]), i + 1);
      end
      s_wdata = 8'h45;
      chk("full_in_ready", int'(w_rdy[0]), 0);
      chk("full_almost_full", int'(w_afl[0]), 1);
      cyc();
      chk("held_count", int'(w_cnt[0]), 4);
      s_oready = 1'b1;
      begin
         bit done;
         int n;
         done = 1'b0;
         n = 0;
         while (!done && n < 10) begin
            done = w_rdy[0];
            n++;
            cyc();
         end
         if (!done) chk("e_accept_timeout", 0, 1);
         chk("e_wait_cycles", n, 2);
      end
      s_wvalid = 1'b0;
      repeat (4) cyc();
      chk("drain_count", int'(w_cnt[0]), 0);
      chk_seq("order", 'h41, 5);

      // Latency: bypass one cycle, prefetch two.
      s_oready = 1'b0;
      s_wdata  = 8'h5A;
      s_wvalid = 1'b1;
      cyc();
      s_wvalid = 1'b0;
      chk("lat1_valid_byp", int'(w_ov[1]), 1);
      chk("lat1_data_byp", int'(w_od[1]), 'h5A);
      chk("lat1_valid_nobyp", int'(w_ov[0]), 0);
      cyc();
      chk("lat2_valid_nobyp", int'(w_ov[0]), 1);
      chk("lat2_data_nobyp", int'(w_od[0]), 'h5A);
      s_oready = 1'b1;
      cyc();
      chk("lat_drain_count0", int'(w_cnt[0]), 0);
      chk("lat_drain_count1", int'(w_cnt[1]), 0);
      chk_seq("lat", 'h5A, 1);

      // Streaming with pointer wrap.
      for (int i = 0; i < 20; i++) begin
         s_wvalid = 1'b1;
         s_wdata  = 8'h10 + 8'(i);
         cyc();
      end
      chk("stream_count0", int'(w_cnt[0]), 2);
      chk("stream_count1", int'(w_cnt[1]), 1);
      chk("stream_nobubble0", got0.size(), 18);
      chk("stream_nobubble1", got1.size(), 19);
      s_wvalid = 1'b0;
      repeat (3) cyc();
      chk_seq("stream", 'h10, 20);

      // Thresholds and flush with a concurrent write.
      s_oready = 1'b0;
      s_af = 3'd3;
      s_ae = 3'd1;
      #1;
      chk("thr0_ae", int'(w_ael[0]), 1);
      chk("thr0_af", int'(w_afl[0]), 0);
      for (int i = 0; i < 3; i++) begin
         s_wvalid = 1'b1;
         s_wdata  = 8'h61 + 8'(i);
         cyc();
         chk($sformatf("thr%0d_ae", i + 1), int'(w_ael[0]), int'(i == 0));
         chk($sformatf("thr%0d_af", i + 1), int'(w_afl[0]), int'(i == 2));
      end
      s_flush  = 1'b1;
      s_wdata  = 8'hEE;
      cyc();
      s_flush  = 1'b0;
      s_wvalid = 1'b0;
      chk("flush_count0", int'(w_cnt[0]), 0);
      chk("flush_count1", int'(w_cnt[1]), 0);
      chk("flush_valid1", int'(w_ov[1]), 0);
      s_oready = 1'b1;
      repeat (2) cyc();
      chk_seq("flush", 0, 0);
      s_af = 3'd0;
      #1;
      chk("af_zero_forced", int'(w_afl[0]), 1);

      // Statistics: fill, overflow attempt, drain, flush, then reset.
      s_oready = 1'b0;
      s_af = 3'd4;
      s_ae = 3'd4;
      for (int i = 0; i < 4; i++) begin
         s_wvalid = 1'b1;
         s_wdata  = 8'h71 + 8'(i);
         cyc();
      end
      chk("ae_ge_n_forced", int'(w_ael[0]), 1);
      chk("af_at_n", int'(w_afl[1]), 1);
      s_wdata = 8'h75;
      cyc();
      s_wvalid = 1'b0;
      s_oready = 1'b1;
      repeat (5) cyc();
      chk_seq("stats", 'h71, 4);
      s_flush = 1'b1;
      cyc();
      s_flush = 1'b0;
      chk("stats_max_after_flush", int'(w_mx[0]), STATS ? 4 : 0);
      chk("stats_ovf_after_flush", int'(w_ovf[1]), STATS ? 1 : 0);
      s_oready = 1'b0;
      s_wvalid = 1'b1;
      s_wdata  = 8'h99;
      repeat (2) cyc();
      s_wvalid = 1'b0;
      s_rst_n  = 1'b0;
      cyc();
      s_rst_n  = 1'b1;
      chk("rst2_count", int'(w_cnt[0]), 0);
      chk("rst2_valid", int'(w_ov[1]), 0);
      chk("rst2_data", int'(w_od[1]), 0);
      chk("rst2_max", int'(w_mx[0]), 0);
      chk("rst2_ovf", int'(w_ovf[0]), 0);
      repeat (2) cyc();
      chk_seq("rst2", 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fifo_sync_flex.md
# fifo_sync_flex

Parametrised synchronous FIFO, successor to the original single-clock FIFO. Adds:
- A prefetched output register whose word counts toward occupancy.
- An optional input-to-output bypass.
- Run-time almost-full and almost-empty thresholds.
- A synchronous flush.
- Optional occupancy statistics.

It sits in the same data paths as the original (host/DSP sample streams, command queues) and uses the same `FIFOInterface` valid/ready handshake on both sides.

## Interface
- `Nb`, 8: data word width in bits.
- `M`, 2: log2 of memory depth; must be at least 1.
- `N`, `1 << M`: memory depth in words; derived, not overridden.
- `BYPASS`, 0: 1 lets a word pass straight from `in` to the output register when the FIFO is empty.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `in`  `FIFOInterface.in`  `Nb`  write side: `data`, `valid`, `ready`.
- `out`  `FIFOInterface.out`  `Nb`  read side: `data`, `valid`, `ready`.
- `flush`  in  1  synchronous discard of all contents.
- `af_level`  in  M+1  almost-full threshold.
- `ae_level`  in  M+1  almost-empty threshold.
- `count`  out  M+1  words held: memory plus output register.
- `almost_full`  out  1  asserted when `count >= af_level`.
- `almost_empty`  out  1  asserted when `count <= ae_level`.
- `max_count`  out  M+1  high-water mark of `count` (statistics build only).
- `overflow`  out  1  sticky: a write was attempted while full (statistics build only).

## Operation
- **Storage.** N-word memory with (M+1)-bit binary read/write pointers; the MSB distinguishes full from empty. Plus one output register (`out.data`, `out.valid`).
- **Occupancy.** `count = (wr_ptr - rd_ptr) + out.valid`, computed mod 2^(M+1). Range is 0..N.
- **Write side.** `in.ready = (count != N)`. It depends only on registered state and never on `out.ready`. A write is accepted when `in.valid && in.ready`.
- **Output slot.** The slot is open when `!out.valid || out.ready`. A transfer occurs when `out.valid && out.ready`.
- **Prefetch.** If the slot is open and memory is non-empty: `out.data <= mem[rd_ptr]`, `out.valid <= 1`, and `rd_ptr` increments.
- **Bypass.** Applies when `BYPASS=1`, memory is empty, the slot is open and a write is accepted. The word goes directly to `out.data`, `out.valid <= 1`, and neither memory nor `wr_ptr` is touched.
- **Slot drain.** If the slot is open and neither prefetch nor bypass occurs, `out.valid <= 0`.
- **Normal write.** Any accepted write that is not bypassed goes to `mem[wr_ptr[M-1:0]]` and `wr_ptr` increments.
- **Simultaneous operation.** Write and prefetch may occur in the same cycle. Pointers wrap naturally mod 2^(M+1).
- **Flush** has priority over all activity in its cycle:
  - Both pointers go to 0 and `out.valid` goes to 0.
  - A write presented in the flush cycle is discarded, even if `in.ready` was 1.
  - Memory contents and `out.data` are left unchanged.
- **Thresholds.** Comparisons are unsigned on M+1 bits.
  - `af_level = 0` forces `almost_full` to 1.
  - `ae_level >= N` forces `almost_empty` to 1.
- **Reset** (`reset = 0` at an edge) clears pointers, `out.valid`, `out.data`, `max_count` and `overflow`. Reset mid-transfer drops all contents with no partial output.

## Timing
- Reset values: `out.valid = 0`, `out.data = 0`, `count = 0`, `in.ready = 1`, `almost_empty = 1` (given `ae_level >= 0`), `almost_full = (af_level == 0)`, `max_count = 0`, `overflow = 0`.
- Latency from accepted write to `out.valid`, with the FIFO empty:
  - `BYPASS=0`: 2 cycles.
  - `BYPASS=1`: 1 cycle.
- Throughput: one word per cycle on each side at steady state, including when full with `out.ready = 1`. In that case `in.ready` returns one cycle after the read frees space.
- `count`, `almost_full`, `almost_empty` and `in.ready` are combinational from registered state only. They reflect the state after the previous edge, with no added lag.
- `out.data` is stable while `out.valid && !out.ready`.
- Flush takes effect at the next edge: `count = 0` one cycle after `flush` is sampled high.

## Configuration
- Macro: `FIFO_SYNC_FLEX_STATS_EN`.
- When defined:
  - `max_count` is updated to `max(max_count, count)` each cycle.
  - `overflow` is set when `in.valid && !in.ready` and held until reset.
  - Flush does not clear either output.
- When undefined: both ports are present but tied to 0, and no statistics logic is built.

## Test plan
- Reset, then N=4, `BYPASS=0`, out stalled. Write 5 words A..E -> A..D accepted; `count` steps 1,2,3,4; `in.ready = 0` at count 4; E held off.
- Raise `out.ready` -> output sequence A,B,C,D with `out.valid` continuous. E is accepted one cycle after space opens and is emitted fifth. `count` returns to 0.
- `BYPASS=1`, empty FIFO, single write 0x5A -> `out.valid = 1` with 0x5A one cycle later; with `BYPASS=0` it appears two cycles later.
- Continuous write plus continuous read for 20 cycles with N=4 -> in-order output and no bubbles after fill. Pointer wrap is exercised and `count` stays constant.
- `af_level = 3`, `ae_level = 1` -> `almost_empty` holds at counts 0 and 1 and drops at 2; `almost_full` rises at count 3. Flush at count 3 together with a write -> `count = 0` next cycle, `out.valid = 0`, and the written word is never output.
- With `FIFO_SYNC_FLEX_STATS_EN`: fill to 4, attempt one write while full, drain, then flush -> `max_count = 4` and `overflow = 1` survive the flush; `reset = 0` clears both.
